// File: rtl/wave_capture_pkg.sv
// wave_capture_pkg: shared state and trigger-mode encodings for trig_wave_capture
package wave_capture_pkg;
    typedef enum logic [1:0] {ST_ARMED, ST_ACTIVE, ST_WAIT} state_t;
    typedef enum logic [1:0] {MODE_RISE, MODE_FALL, MODE_AUTO, MODE_FREE} trig_mode_t;
endpackage

// File: rtl/trig_wave_capture_if.sv
// trig_wave_capture_if: waveform RAM write bus
// write_address {buffer bit, index}, write_enable strobe, write_sample offset-binary data
interface trig_wave_capture_if #(parameter int ADDR_W = 8, parameter int OUT_W = 8);
    logic [ADDR_W:0]  write_address;
    logic             write_enable;
    logic [OUT_W-1:0] write_sample;
    modport master(output write_address, write_enable, write_sample);
    modport slave(input write_address, write_enable, write_sample);
endinterface

// File: rtl/trig_detect.sv
// trig_detect: previous-sample tracking, level-crossing detection and auto-mode timeout
// in: clk, reset, strobe, in_armed, sample, level, mode; out: trig (one-cycle pulse)
module trig_detect
    import wave_capture_pkg::*;
#(
    parameter int SAMPLE_W     = 16,
    parameter int AUTO_TIMEOUT = 1024
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       strobe,
    input  logic                       in_armed,
    input  logic signed [SAMPLE_W-1:0] sample,
    input  logic signed [SAMPLE_W-1:0] level,
    input  trig_mode_t                 mode,
    output logic                       trig
);
    localparam int TO_W = $clog2(AUTO_TIMEOUT + 1);
    logic signed [SAMPLE_W-1:0] prev;
    logic                       prev_valid;
    logic [TO_W-1:0]            to_cnt;
    trig_mode_t                 mode_q;
    logic                       rise, fall, timeout, hit;
    always_comb begin
        rise    = prev < level && sample >= level;
        fall    = prev >= level && sample < level;
        // the count holds earlier strobes, so this strobe is the AUTO_TIMEOUT-th
        timeout = to_cnt == TO_W'(AUTO_TIMEOUT - 1);
        hit     = mode == MODE_RISE ? rise :
                  mode == MODE_FALL ? fall :
                  mode == MODE_AUTO ? rise || timeout : 1'b1;
        trig    = strobe && in_armed && prev_valid && hit;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev       <= '0;
            prev_valid <= 1'b0;
            to_cnt     <= '0;
            mode_q     <= MODE_RISE;
        end else begin
            mode_q <= mode;
            if (strobe) begin
                prev       <= sample;
                prev_valid <= 1'b1;
            end
            if (!in_armed || trig || mode != mode_q)
                to_cnt <= '0;
            else if (strobe && mode == MODE_AUTO)
                to_cnt <= to_cnt + TO_W'(1);
        end
    end
endmodule

// File: rtl/trig_wave_capture.sv
// trig_wave_capture: triggered, decimated double-buffered waveform capture into RAM
// in: clk, reset, new_sample_ready/new_sample_in, wave_display_idle, trig_mode, trig_level, decim
// out: wr (RAM write bus), read_index (displayed buffer), capture_done pulse, armed
module trig_wave_capture
    import wave_capture_pkg::*;
#(
    parameter int SAMPLE_W     = 16,
    parameter int OUT_W        = 8,
    parameter int ADDR_W       = 8,
    parameter int AUTO_TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                new_sample_ready,
    input  logic [SAMPLE_W-1:0] new_sample_in,
    input  logic                wave_display_idle,
    input  logic [1:0]          trig_mode,
    input  logic [SAMPLE_W-1:0] trig_level,
    input  logic [3:0]          decim,
    trig_wave_capture_if.master wr,
    output logic                read_index,
    output logic                capture_done,
    output logic                armed
);
    state_t            state, state_n;
    logic [ADDR_W-1:0] idx, wr_idx;
    logic [3:0]        dcnt, dlat;
    logic [OUT_W-1:0]  samp;
    logic              trig, qual, wr_now, last, flip;

    trig_detect #(.SAMPLE_W(SAMPLE_W), .AUTO_TIMEOUT(AUTO_TIMEOUT)) u_det (
        .clk     (clk),
        .reset   (reset),
        .strobe  (new_sample_ready),
        .in_armed(state == ST_ARMED),
        .sample  ($signed(new_sample_in)),
        .level   ($signed(trig_level)),
        .mode    (trig_mode_t'(trig_mode)),
        .trig    (trig)
    );

    assign armed = state == ST_ARMED;

    always_comb begin
        state_n = state;
        wr_now  = 1'b0;
        wr_idx  = idx + ADDR_W'(1);
        last    = 1'b0;
        flip    = 1'b0;
        qual    = new_sample_ready && dcnt == dlat;
        // top OUT_W bits, sign bit inverted to offset binary
        samp    = new_sample_in[SAMPLE_W-1 -: OUT_W] ^ (OUT_W'(1) << (OUT_W - 1));
        case (state)
            ST_ARMED: if (trig) begin
                state_n = ST_ACTIVE;
                wr_now  = 1'b1;
                wr_idx  = '0;
            end
            ST_ACTIVE: if (qual) begin
                wr_now = 1'b1;
                last   = &wr_idx;
                if (last) state_n = ST_WAIT;
            end
            ST_WAIT: if (wave_display_idle) begin
                state_n = ST_ARMED;
                flip    = 1'b1;
            end
            default: state_n = ST_ARMED;
        endcase
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= ST_ARMED;
        else state <= state_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx              <= '0;
            dcnt             <= '0;
            dlat             <= '0;
            read_index       <= 1'b0;
            capture_done     <= 1'b0;
            wr.write_enable  <= 1'b0;
            wr.write_address <= '0;
            wr.write_sample  <= '0;
        end else begin
            wr.write_enable <= wr_now;
            capture_done    <= last;
            if (wr_now) begin
                idx              <= wr_idx;
                wr.write_address <= {~read_index, wr_idx};
                wr.write_sample  <= samp;
            end
            if (state == ST_ARMED && trig) begin
                dcnt <= '0;
                dlat <= decim;
            end else if (state == ST_ACTIVE && new_sample_ready)
                dcnt <= qual ? 4'd0 : dcnt + 4'd1;
            if (flip) read_index <= ~read_index;
        end
    end
endmodule

// File: tb/tb_trig_wave_capture.sv
// tb_trig_wave_capture: randomized self-checking bench with a behavioural capture model
module tb_trig_wave_capture;
    localparam int SW = 16, OW = 8, AW = 8, TO = 16;

    logic          clk = 1'b0, reset = 1'b1, nsr = 1'b0, idle = 1'b0;
    logic [SW-1:0] nsi = '0, lvl = '0;
    logic [1:0]    mode = 2'd0;
    logic [3:0]    decim = 4'd0;
    logic          read_index, capture_done, armed;

    trig_wave_capture_if #(.ADDR_W(AW), .OUT_W(OW)) wr();

    trig_wave_capture #(.SAMPLE_W(SW), .OUT_W(OW), .ADDR_W(AW), .AUTO_TIMEOUT(TO)) dut (
        .clk              (clk),
        .reset            (reset),
        .new_sample_ready (nsr),
        .new_sample_in    (nsi),
        .wave_display_idle(idle),
        .trig_mode        (mode),
        .trig_level       (lvl),
        .decim            (decim),
        .wr               (wr.master),
        .read_index       (read_index),
        .capture_done     (capture_done),
        .armed            (armed)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0, writes = 0;
    // model: 0 waiting for trigger, 1 capturing, 2 buffer full
    int m_st, m_prev, m_to, m_k, m_n, m_d;
    bit m_pv, m_ri;

    task automatic m_reset();
        m_st = 0; m_prev = 0; m_to = 0; m_pv = 0; m_ri = 0;
    endtask

    task automatic set_mode(input logic [1:0] m);
        if (m != mode) m_to = 0;
        mode = m;
    endtask

    // one strobe: predict from the model, drive, compare the registered write
    task automatic step(input logic [SW-1:0] s);
        int  cur, lv, e_addr, e_data;
        bit  rise, fall, hit, e_we, e_done;
        cur = int'($signed(s));
        lv = int'($signed(lvl));
        e_we = 0; e_done = 0; e_addr = 0;
        e_data = int'(s[15:8]) ^ 128;
        rise = m_pv && m_prev < lv && cur >= lv;
        fall = m_pv && m_prev >= lv && cur < lv;
        if (m_st == 0) begin
            if (mode == 2) m_to++;
            hit = mode == 0 ? rise : mode == 1 ? fall : mode == 2 ? (rise || (m_pv && m_to == TO)) : m_pv;
            if (hit) begin
                m_st = 1; m_k = 0; m_n = 1; m_d = int'(decim); m_to = 0;
                e_we = 1; e_addr = m_ri ? 0 : 256;
            end
        end else if (m_st == 1) begin
            m_k++;
            if (m_k % (m_d + 1) == 0) begin
                e_we = 1; e_addr = (m_ri ? 0 : 256) + m_n; m_n++;
                if (m_n == 256) begin e_done = 1; m_st = 2; end
            end
        end
        m_prev = cur; m_pv = 1;
        @(negedge clk); nsi = s; nsr = 1'b1;
        @(negedge clk); nsr = 1'b0;
        if (wr.write_enable === 1'b1) writes++;
        total++;
        if (wr.write_enable !== e_we) begin
            bad++; $display("FAIL we sample=%h got=%b want=%b", s, wr.write_enable, e_we);
        end
        total++;
        if (capture_done !== e_done) begin
            bad++; $display("FAIL done sample=%h got=%b want=%b", s, capture_done, e_done);
        end
        if (e_we) begin
            total++;
            if (wr.write_address !== 9'(e_addr) || wr.write_sample !== 8'(e_data)) begin
                bad++; $display("FAIL wdata got=%h/%h want=%h/%h", wr.write_address, wr.write_sample, 9'(e_addr), 8'(e_data));
            end
        end
        @(negedge clk);
        total++;
        if (wr.write_enable !== 1'b0 || capture_done !== 1'b0) begin
            bad++; $display("FAIL pulse_len we=%b done=%b", wr.write_enable, capture_done);
        end
    endtask

    task automatic pulse_idle();
        @(negedge clk); idle = 1'b1;
        @(negedge clk); idle = 1'b0;
        if (m_st == 2) begin m_st = 0; m_ri = ~m_ri; m_to = 0; end
        total++;
        if (read_index !== m_ri || armed !== (m_st == 0)) begin
            bad++; $display("FAIL handoff ri=%b armed=%b want %b/%b", read_index, armed, m_ri, m_st == 0);
        end
    endtask

    task automatic test_reset();
        m_reset();
        repeat (3) @(negedge clk);
        total++;
        if (wr.write_enable !== 0 || wr.write_address !== 0 || wr.write_sample !== 0 ||
            read_index !== 0 || capture_done !== 0 || armed !== 1) begin
            bad++; $display("FAIL reset_state we=%b a=%h d=%h ri=%b cd=%b arm=%b", wr.write_enable,
                            wr.write_address, wr.write_sample, read_index, capture_done, armed);
        end
        reset = 1'b0;
        step(16'h0100);
        total++;
        if (writes != 0) begin bad++; $display("FAIL no_prev_trig writes=%0d want=0", writes); end
    endtask

    task automatic test_mode0();
        int w0;
        set_mode(2'd0);
        repeat (3) step(16'hF000);
        step(16'h0100);
        repeat (255) step(16'h0200);
        w0 = writes;
        repeat (3) step(16'h0100);
        total++;
        if (writes != w0 || w0 != 256) begin bad++; $display("FAIL mode0_count writes=%0d want=256", writes); end
    endtask

    task automatic test_handoff();
        pulse_idle();
        total++;
        if (read_index !== 1'b1 || armed !== 1'b1) begin
            bad++; $display("FAIL ri_toggle ri=%b armed=%b want 1/1", read_index, armed);
        end
    endtask

    task automatic test_mode1();
        set_mode(2'd1);
        step(16'h0100);
        step(16'hFF00);
        total++;
        if (wr.write_address !== 9'h000 || wr.write_sample !== 8'h7F) begin
            bad++; $display("FAIL mode1_first got=%h/%h want=000/7f", wr.write_address, wr.write_sample);
        end
        repeat (254) step(16'($urandom));
        step(16'h0300);
        pulse_idle();
    endtask

    task automatic test_mode2();
        int w0, at;
        set_mode(2'd2);
        w0 = writes; at = -1;
        for (int i = 0; i < 16; i++) begin
            step(16'h0200);
            if (at < 0 && writes != w0) at = i + 1;
        end
        total++;
        if (at != 16) begin bad++; $display("FAIL auto_timeout trig_at=%0d want=16", at); end
        repeat (255) step(16'h0200);
        pulse_idle();
    endtask

    task automatic test_mode3();
        int w0;
        set_mode(2'd3);
        w0 = writes;
        step(16'($urandom));
        total++;
        if (writes != w0 + 1) begin bad++; $display("FAIL free_run writes=%0d want=%0d", writes, w0 + 1); end
        repeat (255) step(16'($urandom));
        pulse_idle();
    endtask

    task automatic test_decim();
        int w0;
        decim = 4'd3;
        w0 = writes;
        step(16'h1234);
        repeat (8) step(16'($urandom));
        total++;
        if (writes != w0 + 3) begin bad++; $display("FAIL decim_count writes=%0d want=%0d", writes - w0, 3); end
        @(negedge clk); reset = 1'b1; #1;
        m_reset();
        total++;
        if (wr.write_enable !== 0 || wr.write_address !== 0 || wr.write_sample !== 0 ||
            read_index !== 0 || capture_done !== 0 || armed !== 1) begin
            bad++; $display("FAIL mid_reset we=%b a=%h d=%h ri=%b cd=%b arm=%b", wr.write_enable,
                            wr.write_address, wr.write_sample, read_index, capture_done, armed);
        end
        mode = 2'd0; decim = 4'd0;
        @(negedge clk); reset = 1'b0;
        w0 = writes;
        repeat (5) step(16'h0200);
        total++;
        if (writes != w0) begin bad++; $display("FAIL post_reset writes=%0d want=0", writes - w0); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(7) == 0) begin
                set_mode(2'($urandom_range(3)));
                lvl = 16'($urandom_range(16'h0800) - 16'h0400);
                decim = 4'($urandom_range(3));
            end
            step($urandom_range(1) ? 16'($urandom) : 16'($urandom_range(16'h0600) - 16'h0300));
            if ($urandom_range(5) == 0) pulse_idle();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_mode0();
        test_handoff();
        test_mode1();
        test_mode2();
        test_mode3();
        test_decim();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
